rob_ring: RTL

ROB_RING -- requirements
Module: rob_ring

---
 rtl/rob_ring_if.sv | 51 +++++
 rtl/rob_ring.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/rob_ring_if.sv
// rob_ring_if: dispatch, completion and retire signals of the reorder buffer.
// The master side is the pipeline. The slave side is the ROB.
interface rob_ring_if #(
    parameter int ROB_SIZE     = 16,
    parameter int COMMIT_PORTS = 2,
    parameter int CMPL_PORTS   = 2,
    parameter int PREG_W       = 6,
    parameter int PC_W         = 8
);
    localparam int IDX_W = $clog2(ROB_SIZE);

    // Control
    logic                           flush;

    // Dispatch
    logic                           alloc_valid;
    logic                           alloc_ready;
    logic [PC_W-1:0]                alloc_pc;
    logic [PREG_W-1:0]              alloc_new_preg;
    logic [PREG_W-1:0]              alloc_old_preg;
    logic [IDX_W-1:0]               alloc_idx;

    // Completion
    logic [CMPL_PORTS-1:0]          cmpl_valid;
    logic [CMPL_PORTS*IDX_W-1:0]    cmpl_idx;

    // Retire
    logic [COMMIT_PORTS-1:0]        cmt_valid;
    logic [COMMIT_PORTS*PC_W-1:0]   cmt_pc;
    logic [COMMIT_PORTS*PREG_W-1:0] cmt_new_preg;
    logic [COMMIT_PORTS*PREG_W-1:0] cmt_old_preg;

    // Occupancy
    logic [IDX_W:0]                 count;
    logic                           empty;
    logic                           full;

    modport master (
        output flush, alloc_valid, alloc_pc, alloc_new_preg, alloc_old_preg,
               cmpl_valid, cmpl_idx,
        input  alloc_ready, alloc_idx, cmt_valid, cmt_pc, cmt_new_preg,
               cmt_old_preg, count, empty, full
    );

    modport slave (
        input  flush, alloc_valid, alloc_pc, alloc_new_preg, alloc_old_preg,
               cmpl_valid, cmpl_idx,
        output alloc_ready, alloc_idx, cmt_valid, cmt_pc, cmt_new_preg,
               cmt_old_preg, count, empty, full
    );
endinterface

// File: rtl/rob_ring.sv
// rob_ring: circular reorder buffer.
// Allocation is in order at tail. Completion can arrive out of order by index.
// Up to COMMIT_PORTS entries retire in order from head each cycle.
// head and tail carry an extra wrap bit. This lets full and empty be told
// apart without a separate flag.
module rob_ring #(
    parameter int ROB_SIZE     = 16,
    parameter int COMMIT_PORTS = 2,
    parameter int CMPL_PORTS   = 2,
    parameter int PREG_W       = 6,
    parameter int PC_W         = 8
) (
    input  logic         clk,
    input  logic         rst,
    rob_ring_if.slave    bus
);
    localparam int IDX_W = $clog2(ROB_SIZE);
    localparam int PTR_W = IDX_W + 1;

    // Pointers and per-entry status
    logic [PTR_W-1:0]    head, tail;
    logic [PTR_W-1:0]    head_nxt, tail_nxt;
    logic [PTR_W-1:0]    count;
    logic                full;
    logic [ROB_SIZE-1:0] ent_valid, ent_done;
    logic [ROB_SIZE-1:0] valid_nxt, done_nxt;

    // Entry payload
    logic [PC_W-1:0]     ent_pc       [ROB_SIZE];
    logic [PREG_W-1:0]   ent_new_preg [ROB_SIZE];
    logic [PREG_W-1:0]   ent_old_preg [ROB_SIZE];

    // Per-cycle decisions
    logic                    alloc_fire;
    logic [IDX_W-1:0]        alloc_slot;
    logic [ROB_SIZE-1:0]     cmpl_hit;
    logic [IDX_W-1:0]        cand_idx [COMMIT_PORTS];
    logic [COMMIT_PORTS-1:0] ret_mask;
    logic [PTR_W-1:0]        n_ret;
    logic                    chain;

    // Registered retire outputs
    logic [COMMIT_PORTS-1:0]        cmt_valid_q;
    logic [COMMIT_PORTS*PC_W-1:0]   cmt_pc_q;
    logic [COMMIT_PORTS*PREG_W-1:0] cmt_new_preg_q;
    logic [COMMIT_PORTS*PREG_W-1:0] cmt_old_preg_q;

    // Occupancy and dispatch handshake.
    // alloc_ready uses the pre-edge count, so a slot freed by a retirement
    // this cycle becomes available only on the next cycle.
    assign count      = tail - head;
    assign full       = (count == PTR_W'(ROB_SIZE));
    assign alloc_slot = tail[IDX_W-1:0];
    assign alloc_fire = bus.alloc_valid && !full && !bus.flush;

    assign bus.count        = count;
    assign bus.full         = full;
    assign bus.empty        = (count == '0);
    assign bus.alloc_ready  = !full && !bus.flush;
    assign bus.alloc_idx    = alloc_slot;
    assign bus.cmt_valid    = cmt_valid_q;
    assign bus.cmt_pc       = cmt_pc_q;
    assign bus.cmt_new_preg = cmt_new_preg_q;
    assign bus.cmt_old_preg = cmt_old_preg_q;

    // Decode the completion ports into a one-hot-per-entry hit vector.
    // Duplicate indices simply set the same bit twice.
    always_comb begin
        // NOTE: every always_comb output gets a default before any conditional
        // write. Otherwise a path that skips the assignment infers a latch.
        cmpl_hit = '0;
        for (int p = 0; p < CMPL_PORTS; p++) begin
            if (bus.cmpl_valid[p]) begin
                cmpl_hit[bus.cmpl_idx[p*IDX_W +: IDX_W]] = 1'b1;
            end
        end
    end

    // Select in-order retire candidates.
    // The chain breaks at the first entry that is not valid and done,
    // and it never goes past the occupied range.
    always_comb begin
        ret_mask = '0;
        n_ret    = '0;
        chain    = 1'b1;
        for (int k = 0; k < COMMIT_PORTS; k++) begin
            cand_idx[k] = head[IDX_W-1:0] + IDX_W'(k);
            chain = chain && (PTR_W'(k) < count)
                          && ent_valid[cand_idx[k]] && ent_done[cand_idx[k]];
            ret_mask[k] = chain;
            n_ret       = n_ret + PTR_W'(chain);
        end
    end

    // Next status bits. Steps are applied in this order:
    // complete, retire, allocate, flush.
    // Completion and retirement look only at pre-edge status. So an entry
    // completed this cycle cannot retire until the next one.
    always_comb begin
        valid_nxt = ent_valid;
        done_nxt  = ent_done | (cmpl_hit & ent_valid);
        for (int k = 0; k < COMMIT_PORTS; k++) begin
            if (ret_mask[k]) begin
                valid_nxt[cand_idx[k]] = 1'b0;
                done_nxt[cand_idx[k]]  = 1'b0;
            end
        end
        if (alloc_fire) begin
            valid_nxt[alloc_slot] = 1'b1;
            done_nxt[alloc_slot]  = 1'b0;
        end
        if (bus.flush) begin
            valid_nxt = '0;
            done_nxt  = '0;
        end
    end

    // Next pointer values. A flush returns both pointers to zero.
    always_comb begin
        head_nxt = head + n_ret;
        tail_nxt = tail + PTR_W'(alloc_fire);
        if (bus.flush) begin
            head_nxt = '0;
            tail_nxt = '0;
        end
    end

    // Pointer and status registers.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state registers use non-blocking assignments only. Every
        // flop then samples pre-edge values, whatever order the blocks run in.
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
        end else begin
            head      <= head_nxt;
            tail      <= tail_nxt;
            ent_valid <= valid_nxt;
            ent_done  <= done_nxt;
        end
    end

    // Payload storage, written on an accepted allocation.
    // NOTE: the payload array has no reset. Its contents mean something only
    // while the entry's valid bit is set, and that bit is reset. Leaving the
    // array out of reset keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_pc[alloc_slot]       <= bus.alloc_pc;
            ent_new_preg[alloc_slot] <= bus.alloc_new_preg;
            ent_old_preg[alloc_slot] <= bus.alloc_old_preg;
        end
    end

    // Register the retire strobes and payload. Reset and flush suppress
    // every strobe. The payload of ports that do not retire is don't-care.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmt_valid_q    <= '0;
            cmt_pc_q       <= '0;
            cmt_new_preg_q <= '0;
            cmt_old_preg_q <= '0;
        end else begin
            cmt_valid_q <= bus.flush ? '0 : ret_mask;
            for (int k = 0; k < COMMIT_PORTS; k++) begin
                cmt_pc_q[k*PC_W +: PC_W]           <= ent_pc[cand_idx[k]];
                cmt_new_preg_q[k*PREG_W +: PREG_W] <= ent_new_preg[cand_idx[k]];
                cmt_old_preg_q[k*PREG_W +: PREG_W] <= ent_old_preg[cand_idx[k]];
            end
        end
    end
endmodule
